fb_access_arbiter: RTL and testbench

//  Shares the single-port frame-buffer memory between the VGA pixel-read path and the AHB subordinate write path.
//  VGA reads have absolute priority. AHB writes queue in a small FIFO and drain on idle memory cycles.
//  A sequenced hardware clear fills the whole buffer with one colour using only free cycles.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_wr_fifo.sv | 61 ++++++
 rtl/fb_access_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer access arbiter: FSM states, pixel type and coordinate widths.
package fb_pkg;

  localparam int unsigned FB_X_W   = 10;
  localparam int unsigned FB_Y_W   = 10;
  localparam int unsigned FB_PIX_W = 24;

  typedef logic [FB_PIX_W-1:0] pixel_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fba_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-request queue holding {addr, data}; push is ignored when full, pop when empty.
module fb_wr_fifo #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wptr] <= i_addr;
      r_data[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads first, then hardware clear, then queued AHB writes.
// Optional FBA_PERF_EN adds saturating write-stall and out-of-range-read counters.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 240,
  parameter int unsigned MEM_DEPTH    = 153600,
  parameter int unsigned WFIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  rd_req,
  input  logic [FB_X_W-1:0]     x_coord,
  input  logic [FB_Y_W-1:0]     y_coord,
  output logic                  rd_valid,
  output pixel_t                rd_data,
  input  logic                  clr_req,
  input  pixel_t                clr_color,
  output logic                  clr_busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef FBA_PERF_EN
  output logic [31:0]           perf_wr_stall,
  output logic [31:0]           perf_rd_oob,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_DEPTH);

  fba_state_e            r_state;
  logic [CNT_W-1:0]      r_clr_cnt;
  pixel_t                r_clr_color;
  logic                  r_clr_busy;
  logic                  r_rd_valid;
  logic                  r_rd_hit;
  logic                  r_wr_err;

  logic                  w_rd_in_range;
  logic                  w_rd_grant;
  logic                  w_clr_grant;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_push_try;
  logic                  w_wr_illegal;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_unused_rdata;

  assign w_rd_in_range = (32'(x_coord) < FRAME_WIDTH) && (32'(y_coord) < FRAME_HEIGHT);
  assign w_rd_addr     = ADDR_WIDTH'(y_coord) * ADDR_WIDTH'(FRAME_WIDTH) + ADDR_WIDTH'(x_coord);
  assign w_rd_grant    = rd_req && w_rd_in_range;
  assign w_clr_grant   = !w_rd_grant && (r_state == CLEAR);
  // Queue is frozen during a clear so older clear data never lands on top of newer writes.
  assign w_pop         = !w_rd_grant && (r_state == IDLE) && !w_fifo_empty;

  assign wr_ready      = !w_fifo_full;
  assign w_push_try    = wr_valid && wr_ready;
  assign w_wr_illegal  = (wr_addr >= ADDR_WIDTH'(MEM_DEPTH));
  assign w_push        = w_push_try && !w_wr_illegal;

  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_hit ? mem_rdata[FB_PIX_W-1:0] : '0;
  assign wr_err         = r_wr_err;
  assign clr_busy       = r_clr_busy;
  assign w_unused_rdata = ^mem_rdata[DATA_WIDTH-1:FB_PIX_W];

  fb_wr_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_push),
    .i_addr      (wr_addr),
    .i_data      (wr_data),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // One RAM access per cycle, fixed priority read > clear > queued write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_rd_grant) begin
      mem_en   = 1'b1;
      mem_addr = w_rd_addr;
    end else if (w_clr_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_WIDTH'(r_clr_cnt);
      mem_wdata = DATA_WIDTH'(r_clr_color);
    end else if (w_pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w_head_addr;
      mem_wdata = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_clr_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state     <= CLEAR;
            r_clr_cnt   <= '0;
            r_clr_color <= clr_color;
            r_clr_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (w_clr_grant) begin
            if (r_clr_cnt == CNT_W'(MEM_DEPTH - 1)) begin
              r_state    <= IDLE;
              r_clr_cnt  <= '0;
              r_clr_busy <= 1'b0;
            end else begin
              r_clr_cnt <= r_clr_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read pipe follows the RAM's one-cycle latency; out-of-range reads return zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      r_rd_hit   <= w_rd_grant;
      r_wr_err   <= w_push_try && w_wr_illegal;
    end
  end

`ifdef FBA_PERF_EN
  logic [31:0] r_perf_wr_stall;
  logic [31:0] r_perf_rd_oob;

  assign perf_wr_stall = r_perf_wr_stall;
  assign perf_rd_oob   = r_perf_rd_oob;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_perf_wr_stall <= '0;
      r_perf_rd_oob   <= '0;
    end else begin
      if (!w_fifo_empty && !w_pop && (r_perf_wr_stall != '1))
        r_perf_wr_stall <= r_perf_wr_stall + 32'd1;
      if (rd_req && !w_rd_in_range && (r_perf_rd_oob != '1))
        r_perf_rd_oob <= r_perf_rd_oob + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural 1-cycle RAM; MEM_DEPTH is reduced to 4096 to keep the full clear short.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 320;
  localparam int unsigned FH = 240;
  localparam int unsigned MD = 4096;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          rd_req;
  logic [9:0]    x_coord;
  logic [9:0]    y_coord;
  logic          rd_valid;
  pixel_t        rd_data;
  logic          clr_req;
  pixel_t        clr_color;
  logic          clr_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef FBA_PERF_EN
  logic [31:0]   perf_wr_stall;
  logic [31:0]   perf_rd_oob;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_access_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .MEM_DEPTH    (MD),
    .WFIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_req    (rd_req),
    .x_coord   (x_coord),
    .y_coord   (y_coord),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef FBA_PERF_EN
    .perf_wr_stall (perf_wr_stall),
    .perf_rd_oob   (perf_rd_oob),
`endif
    .mem_rdata (mem_rdata)
  );

  // Behavioural single-port RAM; reads beyond the modelled depth return zero.
  logic [DW-1:0] ram [MD];
  always @(posedge clk) begin
    if (mem_en && mem_we && (mem_addr < MD)) ram[mem_addr[11:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= (mem_addr < MD) ? ram[mem_addr[11:0]] : '0;
  end

  // Write log: every RAM write with the cycle it happened in.
  int            cyc = 0;
  logic [AW-1:0] wlog_addr [$];
  logic [DW-1:0] wlog_data [$];
  int            wlog_cyc  [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n_rst && mem_en && mem_we) begin
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
      wlog_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
    wlog_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    int nbad;
    n_rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; x_coord = '0; y_coord = '0; clr_req = 1'b0; clr_color = '0;
    for (int i = 0; i < int'(MD); i++) ram[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_wr_err",   32'(wr_err),   32'd0);
    check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
    check_eq("rst_mem_en",   32'(mem_en),   32'd0);
    @(negedge clk) n_rst = 1'b1;

    // Read (5,2): address 2*320+5 = 645
    ram[645] = 32'hAA123456;
    @(negedge clk) begin rd_req = 1'b1; x_coord = 10'd5; y_coord = 10'd2; end
    #1;
    check_eq("t1_mem_en",   32'(mem_en), 32'd1);
    check_eq("t1_mem_we",   32'(mem_we), 32'd0);
    check_eq("t1_mem_addr", mem_addr,    32'd645);
    @(negedge clk) rd_req = 1'b0;
    #1;
    check_eq("t1_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("t1_rd_data",  32'(rd_data),  32'h00123456);
    @(negedge clk);
    #1;
    check_eq("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

    // Out-of-range reads (x=320 then y=240), then the last in-range pixel
    @(negedge clk) begin rd_req = 1'b1; x_coord = 10'd320; y_coord = 10'd0; end
    #1;
    check_eq("t2_x_oob_en", 32'(mem_en), 32'd0);
    @(negedge clk) begin x_coord = 10'd0; y_coord = 10'd240; end
    #1;
    check_eq("t2_x_oob_valid", 32'(rd_valid), 32'd1);
    check_eq("t2_x_oob_data",  32'(rd_data),  32'd0);
    check_eq("t2_y_oob_en",    32'(mem_en),   32'd0);
    @(negedge clk) begin x_coord = 10'd319; y_coord = 10'd239; end
    #1;
    check_eq("t2_y_oob_data", 32'(rd_data),  32'd0);
    check_eq("t2_corner_en",  32'(mem_en),   32'd1);
    check_eq("t2_corner_addr", mem_addr,     32'd76799);
    @(negedge clk) rd_req = 1'b0;

    // Five back-to-back pushes while reads hold the RAM: only four fit
    clear_log();
    @(negedge clk) begin rd_req = 1'b1; x_coord = 10'd0; y_coord = 10'd0; end
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = 32'd100 + 32'(i); wr_data = 32'h1000 + 32'(i);
      #1;
      check_eq($sformatf("t3_ready_%0d", i), 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    check_eq("t3_no_wr_during_rd", 32'(wlog_addr.size()), 32'd0);
    check_eq("t3_full",            32'(wr_ready),         32'd0);
    @(negedge clk) rd_req = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t3_wr_count", 32'(wlog_addr.size()), 32'd4);
    if (wlog_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t3_addr_%0d", i), wlog_addr[i], 32'd100 + 32'(i));
        check_eq($sformatf("t3_data_%0d", i), wlog_data[i], 32'h1000 + 32'(i));
        check_eq($sformatf("t3_cyc_%0d", i),  32'(wlog_cyc[i] - wlog_cyc[0]), 32'(i));
      end
    end

    // Illegal addresses are dropped with an error pulse and do not occupy the queue
    clear_log();
    @(negedge clk) begin rd_req = 1'b1; wr_valid = 1'b1; wr_addr = 32'(MD); wr_data = 32'hBAD0; end
    @(negedge clk) begin wr_addr = 32'd200; wr_data = 32'h200; end
    #1;
    check_eq("t4_err_pulse", 32'(wr_err), 32'd1);
    @(negedge clk) begin wr_addr = 32'd201; wr_data = 32'h201; end
    #1;
    check_eq("t4_err_clear", 32'(wr_err), 32'd0);
    @(negedge clk) begin wr_addr = 32'd202; wr_data = 32'h202; end
    @(negedge clk) begin wr_addr = 32'd153600; wr_data = 32'hBAD1; end
    #1;
    check_eq("t4_ready_cnt3", 32'(wr_ready), 32'd1);
    @(negedge clk) wr_valid = 1'b0;
    #1;
    check_eq("t4_err_big",    32'(wr_err),   32'd1);
    check_eq("t4_ready_after", 32'(wr_ready), 32'd1);
    check_eq("t4_no_wr",      32'(wlog_addr.size()), 32'd0);
    @(negedge clk) rd_req = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t4_wr_count", 32'(wlog_addr.size()), 32'd3);
    if (wlog_addr.size() == 3) begin
      check_eq("t4_addr_0", wlog_addr[0], 32'd200);
      check_eq("t4_addr_2", wlog_addr[2], 32'd202);
    end

    // Full clear with reads every other cycle; a write queued mid-clear lands afterwards
    for (int i = 0; i < int'(MD); i++) ram[i] = 32'hDEADBEEF;
    clear_log();
    @(negedge clk) begin clr_req = 1'b1; clr_color = 24'h00FF00; end
    #1;
    check_eq("t5_busy_before", 32'(clr_busy), 32'd0);
    @(negedge clk) begin clr_req = 1'b0; clr_color = 24'h123456; wr_valid = 1'b1; wr_addr = 32'd10; wr_data = 32'h00ABCDEF; end
    #1;
    check_eq("t5_busy", 32'(clr_busy), 32'd1);
    @(negedge clk) begin wr_valid = 1'b0; clr_req = 1'b1; end
    @(negedge clk) clr_req = 1'b0;
    x_coord = 10'd1; y_coord = 10'd1;
    guard = 0;
    while (clr_busy && guard < 20000) begin
      @(negedge clk) rd_req = ~rd_req;
      guard++;
    end
    rd_req = 1'b0;
    check_eq("t5_done_in_time", 32'(guard < 20000), 32'd1);
    repeat (4) @(negedge clk);
    nbad = 0;
    for (int i = 0; i < int'(MD); i++)
      if (ram[i] !== ((i == 10) ? 32'h00ABCDEF : 32'h0000FF00)) nbad++;
    check_eq("t5_bad_words", 32'(nbad),   32'd0);
    check_eq("t5_word0",     ram[0],      32'h0000FF00);
    check_eq("t5_word_last", ram[MD-1],   32'h0000FF00);
    check_eq("t5_word10",    ram[10],     32'h00ABCDEF);
    check_eq("t5_wr_count",  32'(wlog_addr.size()), 32'(MD + 1));
    if (wlog_addr.size() > 0)
      check_eq("t5_last_wr", wlog_addr[wlog_addr.size()-1], 32'd10);

    // Reset at counter 1000 aborts the clear and empties the queue; a new clear starts at 0
    clear_log();
    @(negedge clk) begin clr_req = 1'b1; clr_color = 24'h0000AA; end
    @(negedge clk) begin clr_req = 1'b0; wr_valid = 1'b1; wr_addr = 32'd20; wr_data = 32'h7; end
    @(negedge clk) wr_valid = 1'b0;
    guard = 0;
    while (wlog_addr.size() < 1000 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("t6_reached_1000", 32'(wlog_addr.size()), 32'd1000);
    if (wlog_addr.size() >= 1000) check_eq("t6_addr_999", wlog_addr[999], 32'd999);
    n_rst = 1'b0;
    #1;
    check_eq("t6_busy_rst",  32'(clr_busy), 32'd0);
    check_eq("t6_mem_en_rst", 32'(mem_en),  32'd0);
    @(negedge clk) n_rst = 1'b1;
    clear_log();
    repeat (3) @(negedge clk);
    check_eq("t6_no_wr",    32'(wlog_addr.size()), 32'd0);
    check_eq("t6_idle",     32'(clr_busy), 32'd0);
    check_eq("t6_fifo_rdy", 32'(wr_ready), 32'd1);
    @(negedge clk) begin clr_req = 1'b1; clr_color = 24'h000011; end
    @(negedge clk) clr_req = 1'b0;
    #1;
    check_eq("t6_busy_again", 32'(clr_busy), 32'd1);
    check_eq("t6_restart_we", 32'(mem_we),   32'd1);
    check_eq("t6_restart_a0", mem_addr,      32'd0);
    check_eq("t6_restart_d",  mem_wdata,     32'h00000011);
    @(negedge clk);
    #1;
    check_eq("t6_restart_a1", mem_addr, 32'd1);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
